act_result_serializer: RTL and testbench



---
 rtl/act_stream_pkg.sv | 22 ++
 rtl/act_result_serializer_argmax_lane.sv | 27 ++
 rtl/act_result_serializer.sv | 174 +++++++++++++++++
 tb/tb_act_result_serializer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_stream_pkg.sv
// Shared types and helpers for the activation result serializer.
// Default geometry constants and the per-beat lane slice.
package act_stream_pkg;

   localparam int unsigned DEF_NFMAPS   = 256;
   localparam int unsigned DEF_BITWIDTH = 8;
   localparam int unsigned DEF_LANES    = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Channels [beat*LANES .. beat*LANES+LANES-1] of a default-geometry vector.
   function automatic logic [DEF_LANES*DEF_BITWIDTH-1:0] lane_slice(
      input logic [DEF_NFMAPS*DEF_BITWIDTH-1:0] vec,
      input int unsigned                        beat
   );
      return vec[beat*DEF_LANES*DEF_BITWIDTH +: DEF_LANES*DEF_BITWIDTH];
   endfunction

endpackage

// File: rtl/act_result_serializer_argmax_lane.sv
// act_argmax_lane: combinational max/index over one beat of LANES elements.
// Unsigned compare; ties keep the lowest lane.
module act_argmax_lane
   import act_stream_pkg::*;
#(
   parameter int unsigned LANES    = DEF_LANES,
   parameter int unsigned BITWIDTH = DEF_BITWIDTH,
   localparam int unsigned IW      = (LANES > 1) ? $clog2(LANES) : 1
)(
   input  logic [LANES*BITWIDTH-1:0] lanes,
   output logic [BITWIDTH-1:0]       max_val,
   output logic [IW-1:0]             max_idx
);

   always_comb begin
      max_val = lanes[BITWIDTH-1:0];
      max_idx = '0;
      // Strict greater-than leaves earlier (lower) lanes in place on ties.
      for (int unsigned i = 1; i < LANES; i++) begin
         if (lanes[i*BITWIDTH +: BITWIDTH] > max_val) begin
            max_val = lanes[i*BITWIDTH +: BITWIDTH];
            max_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/act_result_serializer.sv
// Captures wide activation vectors and streams them as LANES-wide beats
// with two-entry buffering and sticky overflow. Optional: ACT_SERIALIZER_ARGMAX_EN.
module act_result_serializer
   import act_stream_pkg::*;
#(
   parameter int unsigned NFMAPS   = DEF_NFMAPS,
   parameter int unsigned BITWIDTH = DEF_BITWIDTH,
   parameter int unsigned LANES    = DEF_LANES,
   localparam int unsigned NBEATS  = NFMAPS / LANES,
   localparam int unsigned BW      = $clog2(NBEATS),
   localparam int unsigned CW      = $clog2(NFMAPS)
)(
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         valid,
   input  logic [NFMAPS*BITWIDTH-1:0]   in_act,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [LANES*BITWIDTH-1:0]    m_data,
   output logic [BW-1:0]                m_beat,
   output logic                         m_last,
   output logic                         overflow,
   output logic                         busy
`ifdef ACT_SERIALIZER_ARGMAX_EN
   ,
   output logic                         class_valid,
   output logic [CW-1:0]                class_idx,
   output logic [BITWIDTH-1:0]          class_score
`endif
);

   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

   state_t                       state_q, state_d;
   logic [NFMAPS*BITWIDTH-1:0]   active_q, pend_q;
   logic                         pend_full_q;
   logic [BW-1:0]                beat_q;
   logic                         overflow_q;

   logic                         sending, hs, last_hs;
   logic                         ld_act_in, ld_act_pend, ld_pend, clr_pend, set_ovf;

   assign sending = (state_q == SEND);
   assign hs      = sending && m_ready;
   assign last_hs = hs && (beat_q == LAST_BEAT);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      ld_act_in   = 1'b0;
      ld_act_pend = 1'b0;
      ld_pend     = 1'b0;
      clr_pend    = 1'b0;
      set_ovf     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (valid) begin
               state_d   = SEND;
               ld_act_in = 1'b1;
            end
         end
         SEND: begin
            if (last_hs) begin
               // Freeing the active slot this cycle lets a coincident vector in without a drop.
               if (pend_full_q) begin
                  ld_act_pend = 1'b1;
                  if (valid) ld_pend  = 1'b1;
                  else       clr_pend = 1'b1;
               end else if (valid) begin
                  ld_act_in = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (valid) begin
               if (pend_full_q) set_ovf = 1'b1;
               else             ld_pend = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_valid  = sending;
      m_beat   = beat_q;
      m_last   = sending && (beat_q == LAST_BEAT);
      overflow = overflow_q;
      busy     = sending || pend_full_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         active_q    <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         beat_q      <= '0;
         overflow_q  <= 1'b0;
      end else begin
         if (ld_act_in)        active_q <= in_act;
         else if (ld_act_pend) active_q <= pend_q;

         if (ld_pend) begin
            pend_q      <= in_act;
            pend_full_q <= 1'b1;
         end else if (clr_pend) begin
            pend_full_q <= 1'b0;
         end

         if (set_ovf) overflow_q <= 1'b1;

         if (last_hs)  beat_q <= '0;
         else if (hs)  beat_q <= beat_q + 1'b1;
      end
   end

   if (NFMAPS == DEF_NFMAPS && BITWIDTH == DEF_BITWIDTH && LANES == DEF_LANES) begin : g_pkg_slice
      assign m_data = lane_slice(active_q, 32'(beat_q));
   end else begin : g_slice
      assign m_data = active_q[32'(beat_q)*LANES*BITWIDTH +: LANES*BITWIDTH];
   end

`ifdef ACT_SERIALIZER_ARGMAX_EN
   localparam int unsigned LIW = (LANES > 1) ? $clog2(LANES) : 1;

   logic [BITWIDTH-1:0] lane_max, run_score, cand_score;
   logic [LIW-1:0]      lane_idx;
   logic [CW-1:0]       lane_chan, run_idx, cand_idx;

   act_argmax_lane #(
      .LANES    (LANES),
      .BITWIDTH (BITWIDTH)
   ) u_argmax_lane (
      .lanes   (m_data),
      .max_val (lane_max),
      .max_idx (lane_idx)
   );

   // Beat 0 restarts the tracker; later beats hold lower channels on ties.
   always_comb begin
      lane_chan  = CW'(32'(beat_q) * LANES + 32'(lane_idx));
      cand_score = run_score;
      cand_idx   = run_idx;
      if (beat_q == '0 || lane_max > run_score) begin
         cand_score = lane_max;
         cand_idx   = lane_chan;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_score   <= '0;
         run_idx     <= '0;
         class_valid <= 1'b0;
         class_idx   <= '0;
         class_score <= '0;
      end else begin
         class_valid <= last_hs;
         if (hs) begin
            run_score <= cand_score;
            run_idx   <= cand_idx;
         end
         if (last_hs) begin
            class_idx   <= cand_idx;
            class_score <= cand_score;
         end
      end
   end
`endif

endmodule

// File: tb/tb_act_result_serializer.sv
// Self-checking bench for act_result_serializer: queue-based reference model,
// per-cycle compare, directed scenarios plus randomized traffic.
`timescale 1ns/1ps
module tb_act_result_serializer;

   localparam int NF = 256;
   localparam int NB = 64;
   typedef logic [NF*8-1:0] vec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        valid = 1'b0;
   vec_t        in_act = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_data;
   logic [5:0]  m_beat;
   logic        m_last;
   logic        overflow;
   logic        busy;
`ifdef ACT_SERIALIZER_ARGMAX_EN
   logic        class_valid;
   logic [7:0]  class_idx;
   logic [7:0]  class_score;
`endif

   act_result_serializer #(
      .NFMAPS   (NF),
      .BITWIDTH (8),
      .LANES    (4)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .valid    (valid),
      .in_act   (in_act),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_beat   (m_beat),
      .m_last   (m_last),
      .overflow (overflow),
      .busy     (busy)
`ifdef ACT_SERIALIZER_ARGMAX_EN
      ,
      .class_valid (class_valid),
      .class_idx   (class_idx),
      .class_score (class_score)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of held vectors (front = being sent) and a beat index.
   vec_t vq[$];
   int   mb = 0;
   bit   movf = 0;
   bit   ecv = 0;
   int   eci = 0;
   int   ecs = 0;

   function automatic int argmax_of(input vec_t v);
      int best = 0;
      for (int c = 1; c < NF; c++)
         if (v[c*8 +: 8] > v[best*8 +: 8]) best = c;
      return best;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vq.delete();
         mb = 0; movf = 0; ecv = 0; eci = 0; ecs = 0;
      end else begin
         vec_t f;
         ecv = 0;
         if (vq.size() > 0 && m_ready) begin
            if (mb == NB - 1) begin
               f   = vq.pop_front();
               eci = argmax_of(f);
               ecs = int'(f[eci*8 +: 8]);
               ecv = 1;
               mb  = 0;
            end else begin
               mb++;
            end
         end
         if (valid) begin
            if (vq.size() < 2) vq.push_back(in_act);
            else               movf = 1;
         end
      end
   end

   always @(negedge clk) begin
      vec_t v;
      if (m_valid && m_ready) hs_cnt++;
      chk("m_valid", 64'(m_valid), 64'(vq.size() > 0));
      chk("busy", 64'(busy), 64'(vq.size() > 0));
      chk("overflow", 64'(overflow), 64'(movf));
      chk("m_last", 64'(m_last), 64'(vq.size() > 0 && mb == NB - 1));
      if (vq.size() > 0) begin
         v = vq[0];
         chk("m_data", 64'(m_data), 64'(v[mb*32 +: 32]));
         chk("m_beat", 64'(m_beat), 64'(mb));
      end
`ifdef ACT_SERIALIZER_ARGMAX_EN
      chk("class_valid", 64'(class_valid), 64'(ecv));
      chk("class_idx", 64'(class_idx), 64'(eci));
      chk("class_score", 64'(class_score), 64'(ecs));
`endif
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic pulse(input vec_t v);
      valid  = 1'b1;
      in_act = v;
      tick();
      valid  = 1'b0;
   endtask

   function automatic vec_t ramp_vec();
      vec_t v;
      for (int c = 0; c < NF; c++) v[c*8 +: 8] = 8'(c);
      return v;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      for (int i = 0; i < NF/4; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((busy || m_valid) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) chk({name, "_timeout"}, 64'(n), 64'(0));
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   n, s, cnt;
      vec_t v;

      repeat (3) tick();
      chk("rst_m_valid", 64'(m_valid), 64'(0));
      chk("rst_m_data", 64'(m_data), 64'(0));
      chk("rst_m_beat", 64'(m_beat), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      rstn = 1'b1;
      tick();

      // Single vector, free-running sink
      m_ready = 1'b1;
      pulse(ramp_vec());
      @(negedge clk);
      chk("t1_first_valid", 64'(m_valid), 64'(1));
      chk("t1_beat0_data", 64'(m_data), 64'h03020100);
      n = 0;
      while (!(m_valid && m_last) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t1_last_offset", 64'(n), 64'(63));
      chk("t1_beat63_data", 64'(m_data), 64'hFFFEFDFC);
      @(negedge clk);
      chk("t1_valid_drop", 64'(m_valid), 64'(0));
      tick();

      // Alternating backpressure: 2 cycles per beat
      m_ready = 1'b0;
      pulse(rnd_vec());
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!m_valid) break;
         cnt++;
         tick();
         m_ready = ~m_ready;
      end
      chk("t2_cycles", 64'(cnt), 64'(128));
      m_ready = 1'b1;
      wait_idle("t2", 50);

      // Back-to-back, second vector 10 cycles later
      s = hs_cnt;
      pulse(rnd_vec());
      repeat (9) tick();
      pulse(rnd_vec());
      n = 0;
      while (!(m_valid && m_last) && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("t3_zero_bubble_valid", 64'(m_valid), 64'(1));
      chk("t3_zero_bubble_beat", 64'(m_beat), 64'(0));
      tick();
      wait_idle("t3", 200);
      chk("t3_beats", 64'(hs_cnt - s), 64'(128));
      chk("t3_overflow", 64'(overflow), 64'(0));

      // Overflow with stalled sink
      m_ready = 1'b0;
      s = hs_cnt;
      pulse(rnd_vec()); tick();
      pulse(rnd_vec()); tick();
      pulse(rnd_vec()); tick();
      chk("t4_overflow", 64'(overflow), 64'(1));
      m_ready = 1'b1;
      wait_idle("t4", 300);
      chk("t4_beats", 64'(hs_cnt - s), 64'(128));
      chk("t4_overflow_sticky", 64'(overflow), 64'(1));

      // Reset mid-stream discards both entries
      pulse(rnd_vec());
      pulse(rnd_vec());
      repeat (5) tick();
      rstn = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(m_valid), 64'(0));
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_overflow", 64'(overflow), 64'(0));
      chk("rst_mid_data", 64'(m_data), 64'(0));
      chk("rst_mid_beat", 64'(m_beat), 64'(0));
      tick();
      rstn = 1'b1;
      tick();

      // Valid coincident with last-beat handshake, pending empty
      s = hs_cnt;
      pulse(rnd_vec());
      repeat (63) tick();
      chk("t5a_at_last", 64'(m_beat), 64'(63));
      pulse(rnd_vec());
      wait_idle("t5a", 200);
      chk("t5a_beats", 64'(hs_cnt - s), 64'(128));
      chk("t5a_overflow", 64'(overflow), 64'(0));

      // Valid coincident with last-beat handshake, pending full
      s = hs_cnt;
      pulse(rnd_vec());
      repeat (4) tick();
      pulse(rnd_vec());
      repeat (58) tick();
      chk("t5b_at_last", 64'(m_beat), 64'(63));
      pulse(rnd_vec());
      wait_idle("t5b", 300);
      chk("t5b_beats", 64'(hs_cnt - s), 64'(192));
      chk("t5b_overflow", 64'(overflow), 64'(0));

`ifdef ACT_SERIALIZER_ARGMAX_EN
      // Tie between channels 17 and 200 resolves to 17
      begin
         int         pulses;
         logic [7:0] gi, gs;
         pulses = 0; gi = '0; gs = '0;
         for (int c = 0; c < NF; c++) v[c*8 +: 8] = 8'h10;
         v[17*8 +: 8]  = 8'hF0;
         v[200*8 +: 8] = 8'hF0;
         pulse(v);
         for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (class_valid) begin
               pulses++;
               gi = class_idx;
               gs = class_score;
            end
         end
         chk("am_pulses", 64'(pulses), 64'(1));
         chk("am_idx", 64'(gi), 64'(17));
         chk("am_score", 64'(gs), 64'hF0);
         tick();
      end
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         valid   = ($urandom_range(0, 99) < 3);
         in_act  = rnd_vec();
         m_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      valid   = 1'b0;
      m_ready = 1'b1;
      wait_idle("rand", 300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
